// File: rtl/coffee_dispense_ctrl.sv
// Coffee dispenser controller: round-robin valve arbiter, level register,
// refill handshake with stall timeout and sticky fault.
module coffee_dispense_ctrl #(
    parameter int NUM_REQ         = 4,
    parameter int LEVEL_W         = 8,
    parameter int FULL_LEVEL      = 100,
    parameter int LOW_THRESH      = 50,
    parameter int CUP_SIZE        = 5,
    parameter int DISPENSE_CYCLES = 4,
    parameter int REFILL_STEP     = 10,
    parameter int REFILL_TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               valve_open,
    output logic [LEVEL_W-1:0] coffee_level,
    output logic               low_status,
    output logic               refill_req,
    input  logic               refill_ack,
    output logic               fault,
    output logic               busy
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DCNT_W = $clog2(DISPENSE_CYCLES) + 1;
    localparam int TCNT_W = $clog2(REFILL_TIMEOUT) + 1;

    localparam logic [LEVEL_W-1:0] FULL_V = LEVEL_W'(FULL_LEVEL);
    localparam logic [LEVEL_W-1:0] LOW_V  = LEVEL_W'(LOW_THRESH);
    localparam logic [LEVEL_W-1:0] CUP_V  = LEVEL_W'(CUP_SIZE);
    localparam logic [LEVEL_W:0]   FULL_X = (LEVEL_W+1)'(FULL_LEVEL);
    localparam logic [LEVEL_W:0]   STEP_X = (LEVEL_W+1)'(REFILL_STEP);

    typedef enum logic [1:0] {IDLE, DISPENSE, REFILL, FAULT} state_t;

    state_t              state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [DCNT_W-1:0]   dcnt;
    logic [TCNT_W-1:0]   tcnt;

    logic                win_valid;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [PTR_W-1:0]    nxt_ptr;
    logic [LEVEL_W:0]    refill_sum;
    logic [LEVEL_W-1:0]  refill_sat;

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        int unsigned idx;
        win_valid  = 1'b0;
        win_onehot = '0;
        nxt_ptr    = rr_ptr;
        idx        = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!win_valid && req[PTR_W'(idx)]) begin
                win_valid              = 1'b1;
                win_onehot[PTR_W'(idx)] = 1'b1;
                nxt_ptr                = PTR_W'((idx + 1) % NUM_REQ);
            end
        end
    end

    // Extra bit keeps the sum from wrapping before saturation.
    assign refill_sum = {1'b0, coffee_level} + STEP_X;
    assign refill_sat = (refill_sum >= FULL_X) ? FULL_V : refill_sum[LEVEL_W-1:0];

    assign low_status = (coffee_level <= LOW_V);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            dcnt         <= '0;
            tcnt         <= '0;
            grant        <= '0;
            valve_open   <= 1'b0;
            coffee_level <= FULL_V;
            refill_req   <= 1'b0;
            fault        <= 1'b0;
        end else begin
            grant <= '0;
            case (state)
                IDLE: begin
                    if (coffee_level < CUP_V) begin
                        state      <= REFILL;
                        refill_req <= 1'b1;
                        tcnt       <= '0;
                    end else if (win_valid) begin
                        grant        <= win_onehot;
                        valve_open   <= 1'b1;
                        coffee_level <= coffee_level - CUP_V;
                        rr_ptr       <= nxt_ptr;
                        dcnt         <= DCNT_W'(DISPENSE_CYCLES - 1);
                        state        <= DISPENSE;
                    end
                end
                DISPENSE: begin
                    if (dcnt == '0) begin
                        valve_open <= 1'b0;
                        if (coffee_level <= LOW_V) begin
                            state      <= REFILL;
                            refill_req <= 1'b1;
                            tcnt       <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        dcnt <= dcnt - DCNT_W'(1);
                    end
                end
                REFILL: begin
                    if (refill_ack) begin
                        coffee_level <= refill_sat;
                        tcnt         <= '0;
                        if (refill_sat == FULL_V) begin
                            refill_req <= 1'b0;
                            state      <= IDLE;
                        end
                    end else if (tcnt == TCNT_W'(REFILL_TIMEOUT - 1)) begin
                        // This increment would reach the timeout: trip now.
                        state      <= FAULT;
                        fault      <= 1'b1;
                        refill_req <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                FAULT: begin
                    fault <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coffee_dispense_ctrl.sv
// Scoreboard bench for coffee_dispense_ctrl: main instance with default
// parameters, second instance with LOW_THRESH=45 for refill saturation.
module tb_coffee_dispense_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] req, grant;
    logic       valve_open, low_status, refill_req, refill_ack, fault, busy;
    logic [7:0] coffee_level;

    logic [3:0] s_req, s_grant;
    logic       s_valve, s_low, s_rreq, s_ack, s_fault, s_busy;
    logic [7:0] s_level;

    coffee_dispense_ctrl u_dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .valve_open(valve_open),
        .coffee_level(coffee_level), .low_status(low_status), .refill_req(refill_req),
        .refill_ack(refill_ack), .fault(fault), .busy(busy)
    );

    coffee_dispense_ctrl #(.LOW_THRESH(45)) u_sat (
        .clk(clk), .rst(rst), .req(s_req), .grant(s_grant), .valve_open(s_valve),
        .coffee_level(s_level), .low_status(s_low), .refill_req(s_rreq),
        .refill_ack(s_ack), .fault(s_fault), .busy(s_busy)
    );

    typedef struct {
        logic [3:0] g;
        logic [7:0] lvl;
    } gexp_t;

    gexp_t      gq[$];
    logic [7:0] rq[$];
    logic [7:0] srq[$];

    int npass  = 0;
    int ntotal = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_grant(input logic [3:0] g, input int lvl);
        gexp_t e;
        e.g   = g;
        e.lvl = 8'(lvl);
        gq.push_back(e);
    endtask

    // Main monitor: grant pulses and level steps while refill_req was high.
    logic       prev_rreq, s_prev_rreq;
    logic [7:0] prev_level, s_prev_level;

    always @(negedge clk) begin
        gexp_t e;
        if (grant !== 4'b0000) begin
            if (gq.size() == 0) chk("grant_unexpected", grant, 0);
            else begin
                e = gq.pop_front();
                chk("grant", grant, e.g);
                chk("grant_level", coffee_level, e.lvl);
            end
        end
        if (prev_rreq === 1'b1 && coffee_level !== prev_level) begin
            if (rq.size() == 0) chk("refill_unexpected", coffee_level, prev_level);
            else chk("refill_level", coffee_level, rq.pop_front());
        end
        prev_rreq  <= refill_req;
        prev_level <= coffee_level;
    end

    always @(negedge clk) begin
        if (s_prev_rreq === 1'b1 && s_level !== s_prev_level) begin
            if (srq.size() == 0) chk("sat_refill_unexpected", s_level, s_prev_level);
            else chk("sat_refill_level", s_level, srq.pop_front());
        end
        s_prev_rreq  <= s_rreq;
        s_prev_level <= s_level;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] one;
        int         cnt;
        int         ok;
        one = 4'b0001;
        rst = 1'b1; req = '0; refill_ack = 1'b0; s_req = '0; s_ack = 1'b0;
        tick(2);
        chk("rst_level", coffee_level, 100);
        chk("rst_low", low_status, 0);
        chk("rst_grant", grant, 0);
        chk("rst_valve", valve_open, 0);
        chk("rst_refill_req", refill_req, 0);
        chk("rst_fault", fault, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Single requester
        push_grant(4'b0100, 95);
        req = 4'b0100;
        tick(1);
        req = '0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (valve_open) cnt++;
            tick(1);
        end
        chk("valve_cycles", cnt, 4);
        chk("busy_after_single", busy, 0);

        // Round-robin drain to 50, then refill
        rst = 1'b1; tick(1); rst = 1'b0;
        for (int k = 0; k < 10; k++) push_grant(one << (k % 4), 95 - 5 * k);
        req = 4'b1111;
        tick(1);
        tick(40);
        chk("rr_spacing_grant9", grant, 4'b0001);
        chk("low_at_55", low_status, 0);
        tick(5);
        chk("low_at_50", low_status, 1);
        tick(4);
        chk("refill_req_on", refill_req, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("no_grant_in_refill", grant, 0);
        end
        for (int v = 60; v <= 100; v += 10) rq.push_back(8'(v));
        push_grant(4'b0100, 95);
        refill_ack = 1'b1;
        tick(5);
        chk("refill_req_off", refill_req, 0);
        refill_ack = 1'b0;
        tick(1);
        req = '0;
        tick(5);
        chk("level_after_refill", coffee_level, 95);

        // Saturation: refill from 45 with ack held (ack ignored outside refill)
        for (int v = 55; v <= 95; v += 10) srq.push_back(8'(v));
        srq.push_back(8'd100);
        s_req = 4'b0001;
        s_ack = 1'b1;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (s_rreq) begin ok = 1; break; end
            tick(1);
        end
        chk("sat_refill_entry", ok, 1);
        chk("sat_level_45", s_level, 45);
        chk("sat_low_45", s_low, 1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!s_rreq) begin ok = 1; break; end
        end
        s_req = '0;
        chk("sat_refill_exit", ok, 1);
        chk("sat_level_full", s_level, 100);
        s_ack = 1'b0;
        tick(6);

        // Refill timeout to fault, then reset
        for (int k = 0; k < 9; k++) push_grant(one << ((k + 3) % 4), 90 - 5 * k);
        req = 4'b1111;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (refill_req) begin ok = 1; break; end
            tick(1);
        end
        chk("timeout_refill_entry", ok, 1);
        tick(15);
        chk("fault_not_yet", fault, 0);
        chk("refill_req_before_timeout", refill_req, 1);
        tick(1);
        chk("fault_set", fault, 1);
        chk("refill_req_cleared_fault", refill_req, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("fault_busy", busy, 1);
            chk("fault_valve", valve_open, 0);
        end
        req = '0;
        rst = 1'b1;
        tick(1);
        chk("fault_cleared_by_rst", fault, 0);
        chk("level_after_rst", coffee_level, 100);
        rst = 1'b0;

        // Reset on the second valve cycle
        push_grant(4'b0001, 95);
        req = 4'b0001;
        tick(1);
        req = '0;
        chk("midop_valve_1", valve_open, 1);
        tick(1);
        chk("midop_valve_2", valve_open, 1);
        rst = 1'b1;
        tick(1);
        chk("midop_valve_dropped", valve_open, 0);
        chk("midop_level", coffee_level, 100);
        chk("midop_busy", busy, 0);
        rst = 1'b0;
        tick(3);

        chk("grant_queue_empty", gq.size(), 0);
        chk("refill_queue_empty", rq.size(), 0);
        chk("sat_queue_empty", srq.size(), 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/coffee_dispense_ctrl.md
Name: coffee_dispense_ctrl

Overview:
- Controller and arbiter in front of the coffee level/status datapath.
- Shares one dispensing valve among NUM_REQ requesters using round-robin arbitration.
- Tracks the coffee level in a register and drives it to the level/status logic.
- Sequences a refill handshake when the level falls to LOW_THRESH or below, and latches a fault if the refill stalls.

Parameters:
- NUM_REQ, 4, number of requesters
- LEVEL_W, 8, width of the level register
- FULL_LEVEL, 100, reset/refill-complete level; must be < 2^LEVEL_W
- LOW_THRESH, 50, low_status asserts when level <= this
- CUP_SIZE, 5, level units removed per grant
- DISPENSE_CYCLES, 4, cycles valve_open is held per grant; >= 1
- REFILL_STEP, 10, level units added per refill_ack cycle
- REFILL_TIMEOUT, 16, consecutive cycles without refill_ack before fault

Ports:
- clk  in  1  system clock; single clock domain; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  request vector; a requester holds its bit until granted
- grant  out  NUM_REQ  one-hot, registered, single-cycle grant pulse
- valve_open  out  1  registered; dispensing valve drive
- coffee_level  out  LEVEL_W  current level register, fed to the level/status logic
- low_status  out  1  combinational, (coffee_level <= LOW_THRESH)
- refill_req  out  1  registered; asserted throughout REFILL
- refill_ack  in  1  each cycle high during REFILL adds REFILL_STEP
- fault  out  1  registered; sticky until rst
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst sampled high at an edge):
  - Outputs: coffee_level=FULL_LEVEL, grant=0, valve_open=0, refill_req=0, fault=0.
  - Internal: state=IDLE, rr_ptr=0, dispense and timeout counters=0.
  - Reset mid-operation aborts at that edge: valve_open drops, no further grant, no partial refill retained.
- States: IDLE, DISPENSE, REFILL, FAULT.
- IDLE:
  - If coffee_level < CUP_SIZE: go to REFILL and set refill_req=1 at the same edge.
  - Otherwise, if any req bit is high: choose the winner as the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - At the next edge: grant = one-hot winner (for 1 cycle), valve_open=1, coffee_level -= CUP_SIZE, rr_ptr = (winner+1) mod NUM_REQ, state=DISPENSE, dispense counter loaded.
  - Latency from req sampled to grant visible: 1 cycle.
- DISPENSE:
  - valve_open stays high for exactly DISPENSE_CYCLES cycles, counted from the grant cycle.
  - grant is 0 after the first DISPENSE cycle.
  - req is ignored; requests are not queued.
  - On the edge ending the last valve cycle: valve_open=0.
  - Next state is REFILL if coffee_level <= LOW_THRESH, otherwise IDLE.
  - Back-to-back grants are therefore spaced DISPENSE_CYCLES+1 cycles apart.
- REFILL:
  - refill_req=1; no grants, even with req held.
  - Each cycle with refill_ack=1: coffee_level = min(coffee_level+REFILL_STEP, FULL_LEVEL); compute in LEVEL_W+1 bits, saturate, no wrap.
  - When the updated level equals FULL_LEVEL: refill_req=0 and state=IDLE at that same edge.
  - Timeout counter clears on every refill_ack=1 and increments otherwise.
  - When it reaches REFILL_TIMEOUT: state=FAULT, fault=1, refill_req=0.
- FAULT:
  - All outputs idle except fault=1 and busy=1.
  - Only rst exits.
- Simultaneous events:
  - rst has priority over everything.
  - The low-level check in IDLE has priority over pending requests.
  - refill_ack outside REFILL is ignored.
- Arithmetic:
  - Level never underflows: a grant is only issued if coffee_level >= CUP_SIZE.
  - low_status threshold is inclusive: 50 → 1, 51 → 0.

Test Plan:
- Reset: hold rst 2 cycles → coffee_level=100, low_status=0, grant=0, valve_open=0, refill_req=0, fault=0, busy=0.
- Single requester: req=4'b0100 held → grant=4'b0100 exactly one cycle after; valve_open high 4 cycles; coffee_level=95; busy back to 0 after 4 cycles.
- Round-robin: req=4'b1111 held → grant sequence 0001, 0010, 0100, 1000, 0001, spaced 5 cycles apart; coffee_level 95, 90, 85, 80, 75.
- Drain and refill:
  - Ten grants take the level to 50; low_status=1 at 50 (0 at 55).
  - refill_req=1 after the tenth dispense, and req held yields no grant.
  - refill_ack held high → level 60, 70, 80, 90, 100; refill_req drops on reaching 100; next grant follows.
- Saturation: enter REFILL at level 45 (CUP_SIZE=5 sequence) → with refill_ack held: 55, 65, 75, 85, 95, then 100 (not 105); refill_req drops.
- Timeout and mid-op reset:
  - In REFILL with refill_ack=0 for 16 cycles → fault=1, refill_req=0; req held gives no grant.
  - Assert rst → fault=0, level=100.
  - Assert rst on the 2nd valve cycle → valve_open=0 at the next edge, coffee_level=100.
